// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   the controller state encoding, the BCD digit width, and the
//   double-dabble adjust constants (threshold and increment).
//   min_digits() returns the number of decimal digits needed to hold
//   the largest unsigned value of a given binary width.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd4;
  localparam logic [DIGIT_W-1:0] ADJ_INC    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counts the decimal digits of 2^binW - 1, which is the same as
  // ceil(binW * log10(2)) for any positive width.
  function automatic int min_digits(input int binW);
    longint unsigned maxVal;
    int              n;
    maxVal = (64'd1 << binW) - 64'd1;
    n      = 0;
    while (maxVal != 64'd0) begin
      maxVal = maxVal / 64'd10;
      n      = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
//   Combinational double-dabble cell: adds 3 to a BCD digit whose value
//   is greater than 4, otherwise passes it through unchanged.
//   Ports:
//     i_digit  in   4-bit BCD digit before the shift
//     o_digit  out  adjusted digit, ready to be shifted left by one
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // A digit of 5..9 would become 10..18 after doubling; pre-adding 3
  // makes the doubled value carry into the next digit correctly.
  always_comb begin
    o_digit = i_digit;
    if (i_digit > ADJ_THRESH) begin
      o_digit = i_digit + ADJ_INC;
    end
  end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd
//   Sequential (one bit per clock) binary-to-BCD converter using the
//   double-dabble algorithm. A value is accepted in IDLE, shifted for
//   BIN_W cycles in SHIFT, and presented in DONE until the consumer
//   takes it. With SIGNED=1 the input is two's complement and the
//   result is reported as sign (neg) plus magnitude digits.
//   Ports:
//     clk        in   clock, all state changes on the rising edge
//     rst        in   asynchronous active-high reset
//     in_valid   in   bin holds a value to convert
//     in_ready   out  converter is idle and will accept bin
//     bin        in   BIN_W-bit value to convert
//     out_valid  out  bcd/neg hold a finished result
//     out_ready  in   consumer takes the result
//     bcd        out  DIGITS BCD digits, digit 0 in bits [3:0]
//     neg        out  result is negative (always 0 when SIGNED=0)
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      neg
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = DIGIT_W * DIGITS;

  // Refuse to build a converter that cannot represent its full range.
  if (BIN_W < 4 || BIN_W > 32) begin : g_badWidth
    $error("seq_bin_to_bcd: BIN_W must be in 4..32");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_badDigits
    $error("seq_bin_to_bcd: DIGITS too small for BIN_W");
  end

  state_t                   r_state;
  state_t                   w_nextState;
  logic [BIN_W-1:0]         r_shift;
  logic [BCD_W-1:0]         r_digits;
  logic [CNT_W-1:0]         r_count;
  logic                     r_neg;
  logic [BCD_W-1:0]         w_adj;
  logic [BCD_W+BIN_W-1:0]   w_shifted;
  logic [BIN_W-1:0]         w_mag;
  logic                     w_binNeg;

  // Sign and magnitude of the incoming value. Negating in BIN_W bits
  // maps the most negative value onto 2^(BIN_W-1), which is exactly the
  // magnitude we want when read back as unsigned.
  assign w_binNeg = (SIGNED != 0) && bin[BIN_W-1];
  assign w_mag    = w_binNeg ? (~bin + {{(BIN_W-1){1'b0}}, 1'b1}) : bin;

  // One adjust cell per digit, all working in parallel on the current
  // digit register before the shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_digits[DIGIT_W*k +: DIGIT_W]),
      .o_digit (w_adj[DIGIT_W*k +: DIGIT_W])
    );
  end

  // The adjusted digits and the binary shift register move left as one
  // long word, so the binary MSB falls into bit 0 of digit 0.
  assign w_shifted = {w_adj, r_shift} << 1;

  // Controller state register; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode. SHIFT leaves on the edge that runs
  // the last iteration, i.e. while the counter still reads 1.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (r_count == CNT_W'(1)) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, one double-dabble step per SHIFT cycle,
  // and hold everything (including the result) in DONE and in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_digits <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift  <= w_mag;
            r_neg    <= w_binNeg;
            r_digits <= '0;
            r_count  <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          {r_digits, r_shift} <= w_shifted;
          r_count             <= r_count - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bcd = r_digits;
  assign neg = r_neg;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// tb_seq_bin_to_bcd
//   Self-checking bench for seq_bin_to_bcd. Three instances share one
//   clock and reset: 8-bit unsigned (A), 8-bit signed (B) and 16-bit
//   unsigned (C). Expected results come from a decimal division model.
module tb_seq_bin_to_bcd;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        inValidA, inReadyA, outValidA, outReadyA, negA;
  logic [7:0]  binA;
  logic [11:0] bcdA;

  logic        inValidB, inReadyB, outValidB, outReadyB, negB;
  logic [7:0]  binB;
  logic [11:0] bcdB;

  logic        inValidC, inReadyC, outValidC, outReadyC, negC;
  logic [15:0] binC;
  logic [19:0] bcdC;

  int checks = 0;
  int errors = 0;

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_dutA (
    .clk(clk), .rst(rst), .in_valid(inValidA), .in_ready(inReadyA), .bin(binA),
    .out_valid(outValidA), .out_ready(outReadyA), .bcd(bcdA), .neg(negA)
  );

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_dutB (
    .clk(clk), .rst(rst), .in_valid(inValidB), .in_ready(inReadyB), .bin(binB),
    .out_valid(outValidB), .out_ready(outReadyB), .bcd(bcdB), .neg(negB)
  );

  seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_dutC (
    .clk(clk), .rst(rst), .in_valid(inValidC), .in_ready(inReadyC), .bin(binC),
    .out_valid(outValidC), .out_ready(outReadyC), .bcd(bcdC), .neg(negC)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by repeated division: the reference for every result.
  function automatic logic [19:0] refDigits(input longint unsigned mag);
    logic [19:0]     r;
    longint unsigned m;
    r = '0;
    m = mag;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(m % 64'd10);
      m           = m / 64'd10;
    end
    return r;
  endfunction

  function automatic void refConv8(input bit sgn, input logic [7:0] v,
                                   output logic [11:0] eBcd, output logic eNeg);
    int          value;
    logic [19:0] full;
    value = sgn ? int'($signed(v)) : int'(v);
    eNeg  = (value < 0);
    full  = refDigits(64'(value < 0 ? -value : value));
    eBcd  = full[11:0];
  endfunction

  // Present one value to A (sgn=0) or B (sgn=1), wait for the result
  // with a bounded budget, and optionally hand it to the consumer.
  task automatic applyStimulus8(input bit sgn, input logic [7:0] v, input bit take,
                                output logic [11:0] oBcd, output logic oNeg, output int lat);
    checkOutput(sgn ? "inReadyB" : "inReadyA", {31'd0, sgn ? inReadyB : inReadyA}, 32'd1);
    if (sgn) begin binB = v; inValidB = 1'b1; end
    else     begin binA = v; inValidA = 1'b1; end
    tick;
    inValidA = 1'b0;
    inValidB = 1'b0;
    lat = 0;
    while (!(sgn ? outValidB : outValidA) && lat < 40) begin
      tick;
      lat++;
    end
    oBcd = sgn ? bcdB : bcdA;
    oNeg = sgn ? negB : negA;
    if (take) begin
      if (sgn) outReadyB = 1'b1; else outReadyA = 1'b1;
      tick;
      outReadyA = 1'b0;
      outReadyB = 1'b0;
    end
  endtask

  task automatic applyStimulus16(input logic [15:0] v, input bit take,
                                 output logic [19:0] oBcd, output int lat);
    checkOutput("inReadyC", {31'd0, inReadyC}, 32'd1);
    binC     = v;
    inValidC = 1'b1;
    tick;
    inValidC = 1'b0;
    lat = 0;
    while (!outValidC && lat < 60) begin
      tick;
      lat++;
    end
    oBcd = bcdC;
    if (take) begin
      outReadyC = 1'b1;
      tick;
      outReadyC = 1'b0;
    end
  endtask

  logic [11:0] gotBcd8, expBcd8;
  logic        gotNeg, expNeg;
  logic [19:0] gotBcd16;
  int          lat;
  int          acc1, acc2, nRes;
  logic [11:0] res[2];
  int          perm[256];
  int          j, t;
  logic [15:0] rv;

  initial begin
    rst = 1'b1;
    inValidA = 1'b0; outReadyA = 1'b0; binA = '0;
    inValidB = 1'b0; outReadyB = 1'b0; binB = '0;
    inValidC = 1'b0; outReadyC = 1'b0; binC = '0;
    #1;
    checkOutput("rstInReadyA", {31'd0, inReadyA}, 32'd1);
    checkOutput("rstOutValidA", {31'd0, outValidA}, 32'd0);
    checkOutput("rstBcdA", {20'd0, bcdA}, 32'd0);
    checkOutput("rstNegB", {31'd0, negB}, 32'd0);
    checkOutput("rstInReadyC", {31'd0, inReadyC}, 32'd1);
    checkOutput("rstBcdC", {12'd0, bcdC}, 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    $display("[TB] unsigned 8-bit 255");
    applyStimulus8(1'b0, 8'd255, 1'b1, gotBcd8, gotNeg, lat);
    checkOutput("u255Lat", 32'(lat), 32'd8);
    checkOutput("u255Bcd", {20'd0, gotBcd8}, 32'h255);
    checkOutput("u255Neg", {31'd0, gotNeg}, 32'd0);

    $display("[TB] back-to-back 0 then 99");
    binA = 8'd0; inValidA = 1'b1; outReadyA = 1'b1;
    acc1 = -1; acc2 = -1; nRes = 0;
    for (int i = 0; i < 40 && nRes < 2; i++) begin
      if (inReadyA) begin
        if (acc1 < 0) acc1 = i;
        else if (acc2 < 0) acc2 = i;
      end
      if (outValidA) begin
        res[nRes] = bcdA;
        nRes++;
      end
      tick;
      if (acc1 >= 0) binA = 8'd99;
    end
    inValidA = 1'b0; outReadyA = 1'b0;
    checkOutput("b2bCount", 32'(nRes), 32'd2);
    checkOutput("b2bFirst", {20'd0, res[0]}, 32'h000);
    checkOutput("b2bSecond", {20'd0, res[1]}, 32'h099);
    checkOutput("b2bSpacing", 32'(acc2 - acc1), 32'd10);

    $display("[TB] signed 8-bit corners");
    applyStimulus8(1'b1, 8'h80, 1'b1, gotBcd8, gotNeg, lat);
    checkOutput("s80Bcd", {20'd0, gotBcd8}, 32'h128);
    checkOutput("s80Neg", {31'd0, gotNeg}, 32'd1);
    applyStimulus8(1'b1, 8'hFF, 1'b1, gotBcd8, gotNeg, lat);
    checkOutput("sFFBcd", {20'd0, gotBcd8}, 32'h001);
    checkOutput("sFFNeg", {31'd0, gotNeg}, 32'd1);
    applyStimulus8(1'b1, 8'h7F, 1'b1, gotBcd8, gotNeg, lat);
    checkOutput("s7FBcd", {20'd0, gotBcd8}, 32'h127);
    checkOutput("s7FNeg", {31'd0, gotNeg}, 32'd0);

    $display("[TB] 16-bit 65535 with consumer stalled");
    applyStimulus16(16'hFFFF, 1'b0, gotBcd16, lat);
    checkOutput("u65535Lat", 32'(lat), 32'd16);
    for (int i = 0; i < 20; i++) begin
      checkOutput("holdBcd", {12'd0, bcdC}, 32'h65535);
      checkOutput("holdInReady", {31'd0, inReadyC}, 32'd0);
      checkOutput("holdOutValid", {31'd0, outValidC}, 32'd1);
      tick;
    end
    outReadyC = 1'b1;
    tick;
    outReadyC = 1'b0;
    checkOutput("releaseInReady", {31'd0, inReadyC}, 32'd1);
    checkOutput("releaseOutValid", {31'd0, outValidC}, 32'd0);

    $display("[TB] reset during SHIFT");
    binC = 16'd1234; inValidC = 1'b1;
    tick;
    inValidC = 1'b0;
    tick; tick; tick; tick;
    checkOutput("midShiftInReady", {31'd0, inReadyC}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstInReady", {31'd0, inReadyC}, 32'd1);
    checkOutput("asyncRstOutValid", {31'd0, outValidC}, 32'd0);
    checkOutput("asyncRstBcd", {12'd0, bcdC}, 32'd0);
    checkOutput("asyncRstNeg", {31'd0, negC}, 32'd0);
    tick;
    rst = 1'b0;
    tick;
    applyStimulus16(16'd4321, 1'b1, gotBcd16, lat);
    checkOutput("after_rst4321Bcd", {12'd0, gotBcd16}, 32'h04321);
    checkOutput("after_rst4321Lat", 32'(lat), 32'd16);

    $display("[TB] random 16-bit values");
    for (int i = 0; i < 8; i++) begin
      rv = 16'($urandom);
      applyStimulus16(rv, 1'b1, gotBcd16, lat);
      checkOutput($sformatf("rand16_%04h", rv), {12'd0, gotBcd16}, {12'd0, refDigits(64'(rv))});
    end

    $display("[TB] shuffled sweep of all 8-bit inputs");
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 256; i++) begin
        applyStimulus8(s[0], 8'(perm[i]), 1'b1, gotBcd8, gotNeg, lat);
        refConv8(s[0], 8'(perm[i]), expBcd8, expNeg);
        checkOutput($sformatf("sweep%0d_%02hBcd", s, perm[i]), {20'd0, gotBcd8}, {20'd0, expBcd8});
        checkOutput($sformatf("sweep%0d_%02hNeg", s, perm[i]), {31'd0, gotNeg}, {31'd0, expNeg});
        checkOutput($sformatf("sweep%0d_%02hLat", s, perm[i]), 32'(lat), 32'd8);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_bin_to_bcd.md
SEQ_BIN_TO_BCD -- requirements
Module: seq_bin_to_bcd

Interface
REQ-001 SHALL have parameter BIN_W, default 16: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 5: number of BCD output digits; DIGITS SHALL be at least ceil(BIN_W*log10(2)), and elaboration SHALL fail otherwise.
REQ-003 SHALL have parameter SIGNED, default 0: 0 treats bin as unsigned; 1 treats bin as two's complement.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: bin holds a valid value.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a value.
REQ-008 SHALL have port bin, input, BIN_W bits: value to convert.
REQ-009 SHALL have port out_valid, output, 1 bit: bcd and neg hold a valid result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port bcd, output, 4*DIGITS bits: digit k occupies bits [4k+3:4k], with digit 0 the least significant.
REQ-012 SHALL have port neg, output, 1 bit: result is negative; always 0 when SIGNED=0.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL assert in_ready in IDLE only, and SHALL assert out_valid in DONE only.
REQ-015 SHALL, in IDLE when in_valid=1, on the clock edge: capture the magnitude into a BIN_W-bit shift register, capture neg, clear the digit register, load the iteration counter with BIN_W, and go to SHIFT.
REQ-016 SHALL, when SIGNED=1 and bin[BIN_W-1]=1, set neg=1 and use magnitude = -bin as a BIN_W-bit unsigned value; -2^(BIN_W-1) SHALL give magnitude 2^(BIN_W-1) without overflow.
REQ-017 SHALL perform exactly one double-dabble iteration per cycle in SHIFT, in this order:
- add 3 to every digit greater than 4, all digits in parallel;
- shift {digits, shift register} left by one bit, so the shift register MSB enters digit 0 bit 0;
- decrement the counter.
REQ-018 SHALL go to DONE on the edge that completes iteration BIN_W, so out_valid rises exactly BIN_W edges after the accepting edge.
REQ-019 SHALL hold bcd and neg stable in DONE until out_ready=1, and on that edge SHALL go to IDLE.
REQ-020 SHALL give a sustained throughput of one result per BIN_W+2 cycles when in_valid and out_ready are both held high.
REQ-021 SHALL ignore in_valid and bin outside IDLE, with no queuing of inputs.
REQ-022 SHALL keep every digit in 0..9 in a valid result, with unused high digits equal to 0.
REQ-023 SHALL drive bcd and neg from registers only, with no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, while rst=1, immediately force:
- state to IDLE;
- in_ready=1, out_valid=0;
- bcd=0, neg=0, counter=0, shift register=0.
REQ-025 SHALL, on reset asserted mid-SHIFT or in DONE, abandon the conversion; the first accept after rst deasserts SHALL convert correctly.

Structure
REQ-026 SHALL place the following in shared package bcd_pkg:
- the state enumeration (IDLE, SHIFT, DONE);
- digit width constant 4;
- adjust threshold constant 4;
- adjust increment constant 3.
REQ-027 SHALL use sub-module bcd_digit_adj, a combinational 4-bit "add 3 if greater than 4" cell, instantiated DIGITS times via generate.
REQ-028 SHALL size the counter as $clog2(BIN_W+1) bits.

Verification
REQ-029 SHALL cover: BIN_W=8, DIGITS=3, SIGNED=0, bin=255 -> out_valid 8 cycles after accept, bcd=0x255, neg=0.
REQ-030 SHALL cover: BIN_W=8, DIGITS=3, bin=0 -> bcd=0x000; then bin=99 back-to-back -> bcd=0x099, with accepts spaced 10 cycles apart.
REQ-031 SHALL cover: BIN_W=8, DIGITS=3, SIGNED=1, bin=0x80 -> neg=1, bcd=0x128; bin=0xFF -> neg=1, bcd=0x001; bin=0x7F -> neg=0, bcd=0x127.
REQ-032 SHALL cover: BIN_W=16, DIGITS=5, bin=65535 with out_ready held low 20 cycles -> bcd=0x65535 stable throughout, in_ready=0, then IDLE one cycle after out_ready.
REQ-033 SHALL cover: rst pulsed at the 5th SHIFT cycle of bin=1234 (BIN_W=16) -> outputs at reset values within the same cycle; next accept of bin=4321 -> bcd=0x04321.
REQ-034 SHALL cover: a randomized sweep of all 2^BIN_W inputs for BIN_W=8 (both SIGNED modes), compared against a golden division model.
